// File: rtl/project_types.sv
// Shared register-file types: reset status, register port info, write-back
// request and HI/LO request.
package project_types;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic REG_ENABLE  = 1'b1;
    localparam logic REG_DISABLE = 1'b0;

    typedef enum logic {
        RST_ENABLE  = 1'b0,
        RST_DISABLE = 1'b1
    } reset_status_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
    } reg_info_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } reg_t;

    typedef struct packed {
        logic                  en;
        logic [REG_DATA_W-1:0] hi;
        logic [REG_DATA_W-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/i_fetch_rreg.sv
// Fetch-stage register read bundle: two read requests in, two data words out.
interface i_fetch_rreg;
    import project_types::*;

    reg_info_t             r1_info;
    reg_info_t             r2_info;
    logic [REG_DATA_W-1:0] r1_data;
    logic [REG_DATA_W-1:0] r2_data;

    modport slave  (input r1_info, r2_info, output r1_data, r2_data);
    modport master (output r1_info, r2_info, input r1_data, r2_data);
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: disabled or r0 reads 0, matching write-back
// is forwarded, otherwise the stored word is returned.
module regfile_rdport
    import project_types::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NREGS  = 32
) (
    input  reg_info_t                      info,
    input  reg_t                           wreq,
    input  logic [NREGS-1:0][DATA_W-1:0]   regs,
    output logic [DATA_W-1:0]              data
);

    // Resolve the port: zero, bypass from write-back, or array lookup.
    always_comb begin
        data = '0;
        if (info.en == REG_ENABLE && info.addr != '0) begin
            if (wreq.en == REG_ENABLE && wreq.addr == info.addr) begin
                data = wreq.data;
            end else begin
                data = regs[info.addr];
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// General-purpose register file with HI/LO pair, two bypassed read ports,
// a registered debug read port and a committed-write counter.
// DATA_W must match project_types::REG_DATA_W since the shared structs carry
// fixed-width data fields.
module regfile
    import project_types::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NREGS  = 32
) (
    input  logic                  clk,
    input  reset_status_t         rst,
    i_fetch_rreg.slave            fetch,
    input  reg_t                  wb_wreg_i,
    input  hilo_t                 wb_hilo_i,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    input  logic [REG_ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]     dbg_data_o,
    output logic [31:0]           wr_count_o
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0]            hi_q, hi_d;
    logic [DATA_W-1:0]            lo_q, lo_d;
    logic [DATA_W-1:0]            dbg_q, dbg_d;
    logic [31:0]                  wr_count_q, wr_count_d;
    logic [DATA_W-1:0]            r1_res, r2_res;
    logic                         in_reset;

    assign in_reset = (rst == RST_ENABLE);

    // Next-state: GPR write with r0 discard, HI/LO pair write, debug sample.
    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbg_d      = '0;
        if (wb_wreg_i.en == REG_ENABLE && wb_wreg_i.addr != '0) begin
            regs_d[wb_wreg_i.addr] = wb_wreg_i.data;
            wr_count_d             = wr_count_q + 32'd1;
        end
        regs_d[0] = '0;
        if (wb_hilo_i.en == REG_ENABLE) begin
            hi_d = wb_hilo_i.hi;
            lo_d = wb_hilo_i.lo;
        end
        if (dbg_addr_i != '0) begin
            dbg_d = regs_q[dbg_addr_i];
        end
    end

    // State registers; reset wipes everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            regs_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbg_q      <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbg_q      <= dbg_d;
            wr_count_q <= wr_count_d;
        end
    end

    regfile_rdport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rd1 (
        .info (fetch.r1_info),
        .wreq (wb_wreg_i),
        .regs (regs_q),
        .data (r1_res)
    );

    regfile_rdport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rd2 (
        .info (fetch.r2_info),
        .wreq (wb_wreg_i),
        .regs (regs_q),
        .data (r2_res)
    );

    // Combinational outputs are forced to 0 while reset is held so that
    // bypass paths cannot leak write-back data during reset.
    always_comb begin
        fetch.r1_data = in_reset ? '0 : r1_res;
        fetch.r2_data = in_reset ? '0 : r2_res;
        hi_o          = '0;
        lo_o          = '0;
        if (!in_reset) begin
            hi_o = (wb_hilo_i.en == REG_ENABLE) ? wb_hilo_i.hi : hi_q;
            lo_o = (wb_hilo_i.en == REG_ENABLE) ? wb_hilo_i.lo : lo_q;
        end
    end

    assign dbg_data_o = dbg_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, r0, disabled port,
// HI/LO, debug port latency and asynchronous reset mid-operation.
module tb_regfile;
    import project_types::*;

    logic                  clk;
    reset_status_t         rst;
    reg_t                  wb_wreg;
    hilo_t                 wb_hilo;
    logic [31:0]           hi_o, lo_o, dbg_data, wr_count;
    logic [4:0]            dbg_addr;
    int                    n_checks;
    int                    n_errors;
    logic [31:0]           exp_cnt;

    i_fetch_rreg fetch_if ();

    regfile dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch_if),
        .wb_wreg_i  (wb_wreg),
        .wb_hilo_i  (wb_hilo),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .wr_count_o (wr_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one GPR write for a single posedge, then release it.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_wreg = '{en: REG_ENABLE, addr: a, data: d};
        @(posedge clk);
        #1;
        wb_wreg.en = REG_DISABLE;
    endtask

    task automatic set_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        fetch_if.r1_info = '{en: e1, addr: a1};
        fetch_if.r2_info = '{en: e2, addr: a2};
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        rst      = RST_ENABLE;
        wb_wreg  = '0;
        wb_hilo  = '0;
        dbg_addr = '0;
        set_rd(REG_DISABLE, 5'd0, REG_DISABLE, 5'd0);

        // Reset state, with bypass inputs active to prove outputs stay 0.
        #2;
        wb_wreg = '{en: REG_ENABLE, addr: 5'd7, data: 32'hCAFEF00D};
        wb_hilo = '{en: REG_ENABLE, hi: 32'h11, lo: 32'h22};
        set_rd(REG_ENABLE, 5'd7, REG_ENABLE, 5'd7);
        #1;
        check_eq("rst_r1", fetch_if.r1_data, 32'h0);
        check_eq("rst_r2", fetch_if.r2_data, 32'h0);
        check_eq("rst_hi", hi_o, 32'h0);
        check_eq("rst_lo", lo_o, 32'h0);
        check_eq("rst_dbg", dbg_data, 32'h0);
        check_eq("rst_cnt", wr_count, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_cnt_edge", wr_count, 32'h0);
        wb_wreg = '0;
        wb_hilo = '0;
        set_rd(REG_DISABLE, 5'd0, REG_DISABLE, 5'd0);
        @(negedge clk);
        rst = RST_DISABLE;

        // Write then read.
        wr(5'd5, 32'hDEADBEEF); exp_cnt++;
        @(negedge clk);
        set_rd(REG_ENABLE, 5'd5, REG_DISABLE, 5'd5);
        #1;
        check_eq("wr_rd_r1", fetch_if.r1_data, 32'hDEADBEEF);
        check_eq("wr_rd_r2_dis", fetch_if.r2_data, 32'h0);
        check_eq("wr_rd_cnt", wr_count, exp_cnt);

        // Same-cycle bypass on both ports.
        @(negedge clk);
        wb_wreg = '{en: REG_ENABLE, addr: 5'd7, data: 32'h12345678};
        set_rd(REG_ENABLE, 5'd7, REG_ENABLE, 5'd7);
        #1;
        check_eq("byp_r1", fetch_if.r1_data, 32'h12345678);
        check_eq("byp_r2", fetch_if.r2_data, 32'h12345678);
        @(posedge clk); #1; exp_cnt++;
        wb_wreg.en = REG_DISABLE;
        #1;
        check_eq("byp_r1_held", fetch_if.r1_data, 32'h12345678);
        check_eq("byp_cnt", wr_count, exp_cnt);

        // Zero register: write is discarded and not counted.
        @(negedge clk);
        wb_wreg = '{en: REG_ENABLE, addr: 5'd0, data: 32'hFFFFFFFF};
        set_rd(REG_ENABLE, 5'd0, REG_ENABLE, 5'd0);
        dbg_addr = 5'd0;
        #1;
        check_eq("r0_byp_r1", fetch_if.r1_data, 32'h0);
        check_eq("r0_byp_r2", fetch_if.r2_data, 32'h0);
        @(posedge clk); #1;
        wb_wreg.en = REG_DISABLE;
        #1;
        check_eq("r0_r1", fetch_if.r1_data, 32'h0);
        check_eq("r0_cnt", wr_count, exp_cnt);
        @(posedge clk); #1;
        check_eq("r0_dbg", dbg_data, 32'h0);

        // Disabled port, including while a matching write is in flight.
        wr(5'd3, 32'hA5A5A5A5); exp_cnt++;
        @(negedge clk);
        set_rd(REG_DISABLE, 5'd3, REG_ENABLE, 5'd3);
        #1;
        check_eq("dis_r1", fetch_if.r1_data, 32'h0);
        check_eq("dis_r2_en", fetch_if.r2_data, 32'hA5A5A5A5);
        wb_wreg = '{en: REG_ENABLE, addr: 5'd3, data: 32'h0F0F0F0F};
        #1;
        check_eq("dis_r1_byp", fetch_if.r1_data, 32'h0);
        check_eq("dis_r2_byp", fetch_if.r2_data, 32'h0F0F0F0F);
        @(posedge clk); #1; exp_cnt++;
        wb_wreg.en = REG_DISABLE;

        // Debug port: one-cycle latency, no bypass.
        @(negedge clk);
        dbg_addr = 5'd5;
        wb_wreg = '{en: REG_ENABLE, addr: 5'd5, data: 32'h11111111};
        @(posedge clk); #1; exp_cnt++;
        wb_wreg.en = REG_DISABLE;
        check_eq("dbg_old", dbg_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        check_eq("dbg_new", dbg_data, 32'h11111111);
        check_eq("dbg_cnt", wr_count, exp_cnt);

        // HI/LO: bypass in the same cycle, then hold.
        @(negedge clk);
        wb_hilo = '{en: REG_ENABLE, hi: 32'h1, lo: 32'h2};
        #1;
        check_eq("hilo_byp_hi", hi_o, 32'h1);
        check_eq("hilo_byp_lo", lo_o, 32'h2);
        @(posedge clk); #1;
        wb_hilo.en = REG_DISABLE;
        wb_hilo.hi = 32'h99;
        wb_hilo.lo = 32'h98;
        #1;
        check_eq("hilo_hold_hi", hi_o, 32'h1);
        check_eq("hilo_hold_lo", lo_o, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        check_eq("hilo_hold2_hi", hi_o, 32'h1);
        check_eq("hilo_cnt", wr_count, exp_cnt);

        // Fill r1..r31, then 10 more writes, then an async reset pulse.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h01010101 * i);
            exp_cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            wr(5'(i + 10), 32'hF0000000 + i);
            exp_cnt++;
        end
        @(negedge clk);
        set_rd(REG_ENABLE, 5'd9, REG_ENABLE, 5'd12);
        dbg_addr = 5'd9;
        #1;
        check_eq("fill_r9", fetch_if.r1_data, 32'h09090909);
        check_eq("fill_r12", fetch_if.r2_data, 32'hF0000002);
        check_eq("fill_cnt", wr_count, exp_cnt);
        @(posedge clk); #1;
        check_eq("fill_dbg9", dbg_data, 32'h09090909);

        @(negedge clk);
        wb_wreg = '{en: REG_ENABLE, addr: 5'd9, data: 32'h77777777};
        wb_hilo = '{en: REG_ENABLE, hi: 32'h55, lo: 32'h66};
        #1;
        rst = RST_ENABLE;
        #1;
        check_eq("arst_r1", fetch_if.r1_data, 32'h0);
        check_eq("arst_r2", fetch_if.r2_data, 32'h0);
        check_eq("arst_hi", hi_o, 32'h0);
        check_eq("arst_lo", lo_o, 32'h0);
        check_eq("arst_dbg", dbg_data, 32'h0);
        check_eq("arst_cnt", wr_count, 32'h0);
        wb_wreg = '0;
        wb_hilo = '0;
        #1;
        rst = RST_DISABLE;
        #1;
        check_eq("post_r9", fetch_if.r1_data, 32'h0);
        check_eq("post_r12", fetch_if.r2_data, 32'h0);
        check_eq("post_hi", hi_o, 32'h0);
        @(posedge clk); #1;
        check_eq("post_dbg9", dbg_data, 32'h0);
        check_eq("post_cnt", wr_count, 32'h0);

        // First write after release is accepted and counted.
        wr(5'd2, 32'hBEEF0002);
        @(negedge clk);
        set_rd(REG_ENABLE, 5'd2, REG_ENABLE, 5'd9);
        #1;
        check_eq("first_wr_r2", fetch_if.r1_data, 32'hBEEF0002);
        check_eq("first_wr_r9", fetch_if.r2_data, 32'h0);
        check_eq("first_wr_cnt", wr_count, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
